seq_det_10110: RTL and testbench
================================

SEQ_DET_10110 -- requirements
Module: seq_det_10110

Interface
REQ-001 Parameter: CNT_W, default 8, width of the match counter (legal range 1..32).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: in  input  1  serial data bit, sampled on each rising clk edge.
REQ-005 Port: out  output  1  detect flag, high while FSM is in state DET.
REQ-006 Port: match_count  output  CNT_W  number of detections since reset, saturating.

Function
REQ-007 Block SHALL be a Moore FSM detecting serial pattern 1-0-1-1-0 (first bit received first).
REQ-008 States SHALL be: IDLE (no prefix), S1 ("1"), S10 ("10"), S101 ("101"), S1011 ("1011"), DET ("10110" complete).
REQ-009 Transitions on in=0/in=1: IDLE->IDLE/S1; S1->S10/S1; S10->IDLE/S101; S101->S10/S1011; S1011->DET/S1.
REQ-010 DET transitions SHALL depend on configuration (REQ-021/022).
REQ-011 out SHALL be decoded from the state register only, with no combinational path from in to out.
REQ-012 Latency: out SHALL go high for the clock cycle that follows the edge sampling the final 0 of the pattern.
REQ-013 out SHALL stay high for exactly one cycle per detection; back-to-back detections are separate one-cycle pulses.
REQ-014 match_count SHALL increment by 1 on the same edge that enters DET.
REQ-015 match_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-016 in is sampled every cycle; there is no enable or stall.

Reset
REQ-017 While rst=0: state SHALL be IDLE, out SHALL be 0 and match_count SHALL be 0, asynchronously and independent of clk.
REQ-018 Reset asserted mid-pattern SHALL discard the partial match; after release, detection restarts from IDLE.
REQ-019 in SHALL be ignored while rst=0.
REQ-020 First sampling edge SHALL be the first rising clk edge with rst=1.

Configuration
REQ-021 With macro SEQ_DET_10110_OVERLAP_EN defined, overlapping detection SHALL apply: DET->S101 on in=1, DET->IDLE on in=0 (suffix "10" reused).
REQ-022 Without SEQ_DET_10110_OVERLAP_EN, non-overlapping detection SHALL apply: DET->S1 on in=1, DET->IDLE on in=0 (no bit of a completed match reused).
REQ-023 All other transitions, outputs and reset behaviour SHALL be identical in both builds.

Structure
REQ-024 Package seq_det_10110_pkg SHALL hold the state enum (3-bit encoding, IDLE=0) and the pattern constant 5'b10110.
REQ-025 A sub-module sat_counter (parameter width, async active-low reset, increment input, saturating output) SHALL implement match_count.
REQ-026 Next-state logic SHALL be one combinational block; the state register SHALL be one sequential block.

Verification
REQ-027 Reset: rst=0 with random in toggling -> out=0, match_count=0 throughout.
REQ-028 Single match: release reset, in=1,0,1,1,0 -> out=1 for one cycle after the 5th bit, match_count=1.
REQ-029 Overlap: in=1,0,1,1,0,1,1,0 -> with OVERLAP_EN two pulses (after bits 5 and 8), match_count=2; without it one pulse, match_count=1.
REQ-030 Near-miss: in=1,0,1,0,1,0,1,1,1 -> out stays 0, match_count unchanged.
REQ-031 Mid-pattern reset: in=1,0,1,1, then rst=0 for one cycle, then in=0 -> no pulse; a following full 1,0,1,1,0 -> one pulse.
REQ-032 Saturation: CNT_W=2, apply five non-overlapping matches -> match_count saturates at 3 and stays at 3.

Source files
------------

// File: rtl/seq_det_10110_pkg.sv
// Shared definitions for the 1-0-1-1-0 serial sequence detector.
//   state_t : FSM state encoding (3 bits, IDLE = 0)
//   PATTERN : the detected bit sequence, MSB is the first bit received
package seq_det_10110_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4,
    DET   = 3'd5
  } state_t;

  localparam logic [4:0] PATTERN = 5'b10110;

endpackage

// File: rtl/seq_det_10110_sat_counter.sv
// Saturating up-counter used for the detector's match count.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears count
//   inc   : increment request for this edge
//   count : current value, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seq_det_10110.sv
// Moore FSM detecting the serial pattern 1-0-1-1-0 (first bit first).
// Ports:
//   clk         : clock, all state changes on the rising edge
//   rst         : asynchronous active-low reset
//   in          : serial data bit, sampled every rising edge
//   out         : high for the single cycle the FSM sits in DET
//   match_count : saturating count of detections since reset
// Parameter CNT_W sets the match_count width (1..32).
// Build option: define SEQ_DET_10110_OVERLAP_EN to let the trailing "10"
// of a completed match start the next one; otherwise matches do not overlap.
module seq_det_10110
  import seq_det_10110_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  state_t state;
  state_t next_state;
  logic   enter_det;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    unique case (state)
      IDLE:    next_state = in ? S1    : IDLE;
      S1:      next_state = in ? S1    : S10;
      S10:     next_state = in ? S101  : IDLE;
      S101:    next_state = in ? S1011 : S10;
      S1011:   next_state = in ? S1    : DET;
`ifdef SEQ_DET_10110_OVERLAP_EN
      DET:     next_state = in ? S101  : IDLE;
`else
      DET:     next_state = in ? S1    : IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // DET is only ever entered from S1011, never held, so one increment per match.
  assign enter_det = (next_state == DET);
  assign out       = (state == DET);

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (enter_det),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_det_10110.sv
module tb_seq_det_10110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in  = 1'b0;
  logic       out_a, out_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic       out;
    int         cnt;
  } exp_t;
  exp_t sb[$];

  // Reference model: window of recent bits plus how many of them may still
  // contribute to a match.
  logic [4:0] hist  = '0;
  int         avail = 0;
  int         mcnt  = 0;

  seq_det_10110 dut_a (
    .clk(clk), .rst(rst), .in(in), .out(out_a), .match_count(cnt_a)
  );

  seq_det_10110 #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in(in), .out(out_b), .match_count(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist  = '0;
    avail = 0;
    mcnt  = 0;
    sb.delete();
  endtask

  // Drive one bit, push model expectation, then compare after the edge.
  task automatic send_bit(input logic b, input string tag);
    exp_t e, g;
    @(negedge clk);
    in = b;
    hist = {hist[3:0], b};
    if (avail < 5) avail++;
    e.out = (avail >= 5) && (hist == 5'b10110);
    if (e.out) begin
      mcnt++;
`ifdef SEQ_DET_10110_OVERLAP_EN
      avail = 2;
`else
      avail = 0;
`endif
    end
    e.cnt = mcnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      g = sb.pop_front();
      check({tag, "_out"},   int'(out_a), int'(g.out));
      check({tag, "_cnt"},   int'(cnt_a), g.cnt);
      check({tag, "_out2"},  int'(out_b), int'(g.out));
      check({tag, "_cnt2"},  int'(cnt_b), (g.cnt > 3) ? 3 : g.cnt);
    end
  endtask

  task automatic send_seq(input logic [15:0] bits, input int n, input string tag);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], tag);
  endtask

  initial begin
    int pulses;

    // Reset held with in toggling randomly: outputs stay cleared.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("reset_out",  int'(out_a), 0);
      check("reset_cnt",  int'(cnt_a), 0);
      check("reset_cnt2", int'(cnt_b), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Single match.
    send_seq(16'b10110, 5, "single");
    check("single_total", int'(cnt_a), 1);

    // Overlap stream; expected pulse count depends on the build.
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] pat;
      pat = 8'b10110110;
      send_bit(pat[i], "overlap");
      if (out_a) pulses++;
    end
`ifdef SEQ_DET_10110_OVERLAP_EN
    check("overlap_pulses", pulses, 2);
    check("overlap_total", int'(cnt_a), 2);
`else
    check("overlap_pulses", pulses, 1);
    check("overlap_total", int'(cnt_a), 1);
`endif

    // Near miss: no detection, count unchanged.
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    send_seq(16'b101010111, 9, "nearmiss");
    check("nearmiss_total", int'(cnt_a), 0);

    // Mid-pattern reset discards the partial match.
    send_seq(16'b1011, 4, "mid_pre");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_async_out", int'(out_a), 0);
    check("mid_async_cnt", int'(cnt_a), 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    send_bit(1'b0, "mid_zero");
    check("mid_no_pulse", int'(out_a), 0);
    send_seq(16'b10110, 5, "mid_full");
    check("mid_full_total", int'(cnt_a), 1);

    // Saturation of the 2-bit counter across five separated matches.
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int m = 0; m < 5; m++) begin
      send_seq(16'b10110, 5, "sat");
      send_seq(16'b000, 3, "sat_gap");
    end
    check("sat_cnt2", int'(cnt_b), 3);
    check("sat_cnt8", int'(cnt_a), 5);

    // Async reset asserted while in DET clears the pulse immediately.
    send_seq(16'b10110, 5, "det_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("det_rst_out", int'(out_a), 0);
    check("det_rst_cnt", int'(cnt_b), 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
